// File: rtl/router_reg.sv
// -----------------------------------------------------------------------------
// router_reg
//   Datapath register stage of the 1x3 packet router. It sits between the
//   router control FSM and the three output FIFOs. It:
//     - latches the header byte while the FSM decodes the address,
//     - forwards the header, payload and parity bytes to the FIFO write bus,
//     - parks a byte that arrives while the selected FIFO is full and
//       replays it when the FSM enters LOAD_AFTER_FULL,
//     - accumulates a running XOR parity over header and payload and flags a
//       mismatch against the received parity byte,
//     - reports packet end (low_pkt_valid) and parity delivery (parity_done).
//
//   Optional feature: define ROUTER_REG_PARITY_CHECK_EN to build the parity
//   checker (int_parity, pkt_parity, err). Without it, err is tied to 0.
//   parity_done and low_pkt_valid behave the same in both builds.
//
// Ports
//   clock        in   rising-edge clock
//   resetn       in   synchronous, active-low reset
//   pkt_valid    in   source byte valid; low on the parity byte
//   data_in      in   source byte (header, payload or parity)
//   fifo_full    in   full flag of the selected output FIFO
//   detect_add   in   FSM in DECODE_ADDRESS
//   lfd_state    in   FSM in LOAD_FIRST_DATA
//   ld_state     in   FSM in LOAD_DATA
//   laf_state    in   FSM in LOAD_AFTER_FULL
//   full_state   in   FSM in FIFO_FULL_STATE (observability only)
//   rst_int_reg  in   FSM in CHECK_PARITY_ERROR
//   dout         out  byte to FIFO write port
//   parity_done  out  parity byte has been delivered to dout
//   low_pkt_valid out pkt_valid fell while loading (packet end seen)
//   err          out  computed parity differs from received parity byte
//
// Handshake: there is no ready back to the source. A byte on data_in is
// consumed on a clock edge where ld_state is high; pkt_valid qualifies it as
// payload (high) or parity (low). fifo_full is the downstream back-pressure:
// a byte consumed while fifo_full is high is parked in hold_byte and is
// written out on the laf_state edge instead. The FSM guarantees that no
// second byte is consumed before that replay.
// -----------------------------------------------------------------------------
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] header_byte;
  logic [DATA_WIDTH-1:0] hold_byte;

  // full_state changes nothing here; it is a port only so checkers can see it.
  logic unused_full_state;
  assign unused_full_state = full_state;

  // Strobe decodes shared by several registers.
  logic capture_header;
  logic load_direct;
  logic load_parked;
  logic parity_byte;
  logic set_parity_done;

  assign capture_header  = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
  assign load_direct     = ld_state && !fifo_full;
  assign load_parked     = ld_state && fifo_full;
  assign parity_byte     = ld_state && !pkt_valid;
  // The laf term covers the parity byte that was parked under fifo_full.
  assign set_parity_done = (load_direct && !pkt_valid) ||
                           (laf_state && low_pkt_valid && !parity_done);

  // Header and parked-byte registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_byte <= '0;
      hold_byte   <= '0;
    end else begin
      if (capture_header) header_byte <= data_in;
      if (load_parked)    hold_byte   <= data_in;
    end
  end

  // FIFO write bus, highest-priority strobe first.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      dout <= '0;
    end else if (lfd_state) begin
      dout <= header_byte;
    end else if (load_direct) begin
      dout <= data_in;
    end else if (laf_state) begin
      dout <= hold_byte;
    end
  end

  // Packet-end and parity-delivered flags.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
      parity_done   <= 1'b0;
    end else begin
      if (rst_int_reg)      low_pkt_valid <= 1'b0;
      else if (parity_byte) low_pkt_valid <= 1'b1;

      if (detect_add)           parity_done <= 1'b0;
      else if (set_parity_done) parity_done <= 1'b1;
    end
  end

`ifdef ROUTER_REG_PARITY_CHECK_EN
  logic [DATA_WIDTH-1:0] int_parity;
  logic [DATA_WIDTH-1:0] pkt_parity;

  // Payload bytes are accumulated on their single ld_state cycle, parked or
  // not, so the laf replay never adds a byte twice.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      int_parity <= '0;
      pkt_parity <= '0;
      err        <= 1'b0;
    end else if (detect_add) begin
      int_parity <= '0;
      pkt_parity <= '0;
      err        <= 1'b0;
    end else begin
      if (lfd_state)                  int_parity <= int_parity ^ header_byte;
      else if (ld_state && pkt_valid) int_parity <= int_parity ^ data_in;

      if (parity_byte) pkt_parity <= data_in;

      // err holds once parity_done drops so it stays valid for the FSM.
      if (parity_done) err <= (int_parity != pkt_parity);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
